// File: rtl/rvsteel_bus_arbiter_pkg.sv
// Shared definitions for the rvsteel two-manager bus arbiter: bus widths,
// default abort data pattern, arbiter state type and the round-robin pick.
package rvsteel_bus_arbiter_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int STROBE_WIDTH = 4;

  localparam logic [DATA_WIDTH-1:0] DEFAULT_ERROR_DATA = 32'hdeadbeef;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arbState_e;

  // On a tie the manager that did not win last time goes next.
  function automatic logic pickManager(input logic req0, input logic req1,
                                       input logic lastGrant);
    if (req0 && req1) begin
      return ~lastGrant;
    end
    return req1;
  endfunction

endpackage

// File: rtl/rvsteel_bus_arbiter_watchdog.sv
// Cycle counter that flags a granted transaction which has gone
// TIMEOUT_CYCLES cycles without a subordinate response.
module rvsteel_bus_arbiter_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/rvsteel_bus_arbiter.sv
// Two-manager round-robin arbiter for the rvsteel system bus: one transaction
// at a time, responses routed back to the owner, hung transactions aborted.
module rvsteel_bus_arbiter
  import rvsteel_bus_arbiter_pkg::*;
#(
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = DEFAULT_ERROR_DATA
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   m0_rw_address,
  input  logic                    m0_read_request,
  input  logic                    m0_write_request,
  input  logic [DATA_WIDTH-1:0]   m0_write_data,
  input  logic [STROBE_WIDTH-1:0] m0_write_strobe,
  output logic [DATA_WIDTH-1:0]   m0_read_data,
  output logic                    m0_read_response,
  output logic                    m0_write_response,
  input  logic [ADDR_WIDTH-1:0]   m1_rw_address,
  input  logic                    m1_read_request,
  input  logic                    m1_write_request,
  input  logic [DATA_WIDTH-1:0]   m1_write_data,
  input  logic [STROBE_WIDTH-1:0] m1_write_strobe,
  output logic [DATA_WIDTH-1:0]   m1_read_data,
  output logic                    m1_read_response,
  output logic                    m1_write_response,
  output logic [ADDR_WIDTH-1:0]   s_rw_address,
  output logic                    s_read_request,
  output logic                    s_write_request,
  output logic [DATA_WIDTH-1:0]   s_write_data,
  output logic [STROBE_WIDTH-1:0] s_write_strobe,
  input  logic [DATA_WIDTH-1:0]   s_read_data,
  input  logic                    s_read_response,
  input  logic                    s_write_response,
  output logic                    bus_error
);

  arbState_e state_q, state_d;
  logic      lastGrant_q, lastGrant_d;
  logic      isWrite_q, isWrite_d;

  logic m0Req, m1Req, granted, grantIdx, finish, expired, wdClear;
  logic respRead, respWrite;
  logic [DATA_WIDTH-1:0]   respData;
  logic [ADDR_WIDTH-1:0]   selAddr;
  logic [DATA_WIDTH-1:0]   selData;
  logic [STROBE_WIDTH-1:0] selStrobe;
  logic                    selRead, selWrite;

  assign m0Req    = m0_read_request | m0_write_request;
  assign m1Req    = m1_read_request | m1_write_request;
  assign granted  = (state_q != IDLE);
  assign grantIdx = (state_q == GRANT1);

  assign selAddr   = grantIdx ? m1_rw_address    : m0_rw_address;
  assign selData   = grantIdx ? m1_write_data    : m0_write_data;
  assign selStrobe = grantIdx ? m1_write_strobe  : m0_write_strobe;
  assign selRead   = grantIdx ? m1_read_request  : m0_read_request;
  assign selWrite  = grantIdx ? m1_write_request : m0_write_request;

  assign wdClear = ~granted | finish;

  rvsteel_bus_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (wdClear),
    .enable_i (granted),
    .expired_o(expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      isWrite_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      isWrite_q   <= isWrite_d;
    end
  end

  // Transaction type is latched at grant so a response of the wrong kind is ignored.
  always_comb begin
    state_d         = state_q;
    lastGrant_d     = lastGrant_q;
    isWrite_d       = isWrite_q;
    s_rw_address    = '0;
    s_read_request  = 1'b0;
    s_write_request = 1'b0;
    s_write_data    = '0;
    s_write_strobe  = '0;
    respRead        = 1'b0;
    respWrite       = 1'b0;
    respData        = '0;
    bus_error       = 1'b0;
    finish          = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0Req || m1Req) begin
          if (pickManager(m0Req, m1Req, lastGrant_q)) begin
            state_d   = GRANT1;
            isWrite_d = m1_write_request;
          end else begin
            state_d   = GRANT0;
            isWrite_d = m0_write_request;
          end
        end
      end
      GRANT0, GRANT1: begin
        s_rw_address    = selAddr;
        s_write_data    = selData;
        s_write_strobe  = selStrobe;
        s_read_request  = selRead & ~selWrite;
        s_write_request = selWrite;
        respData        = s_read_data;
        if (isWrite_q ? s_write_response : s_read_response) begin
          finish    = 1'b1;
          respRead  = ~isWrite_q;
          respWrite = isWrite_q;
        end else if (expired) begin
          finish          = 1'b1;
          respRead        = ~isWrite_q;
          respWrite       = isWrite_q;
          respData        = ERROR_DATA;
          s_read_request  = 1'b0;
          s_write_request = 1'b0;
          bus_error       = 1'b1;
        end
        if (finish) begin
          state_d     = IDLE;
          lastGrant_d = grantIdx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_read_data      = '0;
    m0_read_response  = 1'b0;
    m0_write_response = 1'b0;
    m1_read_data      = '0;
    m1_read_response  = 1'b0;
    m1_write_response = 1'b0;
    if (granted && grantIdx) begin
      m1_read_data      = respData;
      m1_read_response  = respRead;
      m1_write_response = respWrite;
    end else if (granted) begin
      m0_read_data      = respData;
      m0_read_response  = respRead;
      m0_write_response = respWrite;
    end
  end

endmodule
